life_scheduler: RTL and testbench

LIFE_SCHEDULER -- requirements
Module: life_scheduler

---
 rtl/life_pkg.sv | 27 ++
 rtl/life_mem_arbiter.sv | 45 ++++
 rtl/life_scheduler.sv | 148 ++++++++++++++
 tb/tb_life_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the Life generation scheduler.
//   life_state_t  : scheduler FSM state encoding
//   FRAME_W       : width of the frame counter / frames-per-generation target
//   speed_frames(): maps the 2-bit speed selector to frames per generation
package life_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_COMPUTE    = 2'd2,
      ST_SWAP       = 2'd3
   } life_state_t;

   localparam int FRAME_W = 6;

   function automatic logic [FRAME_W-1:0] speed_frames(input logic [1:0] speed);
      logic [FRAME_W-1:0] frames;
      case (speed)
         2'd0:    frames = 6'd1;
         2'd1:    frames = 6'd4;
         2'd2:    frames = 6'd15;
         default: frames = 6'd60;
      endcase
      return frames;
   endfunction

endpackage

// File: rtl/life_mem_arbiter.sv
// Grant and address mux for the single-port cell memory.
// The display always wins; the engine only gets the port while a generation
// is being computed and the display is not reading. The display reads the
// shown buffer, the engine works on the other one.
//   disp_req/disp_addr       : display read request and cell address
//   eng_req/eng_we/eng_addr  : engine request, write enable and cell address
//   buf_sel                  : buffer currently displayed
//   eng_window               : engine may be granted (computing, not in reset)
//   disp_gnt/eng_gnt         : grants (mutually exclusive)
//   mem_addr/mem_we          : memory address {buffer, cell} and write enable
module life_mem_arbiter
   import life_pkg::*;
#(
   parameter int ADDR_W = 11
) (
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   input  logic              eng_req,
   input  logic              eng_we,
   input  logic [ADDR_W-1:0] eng_addr,
   input  logic              buf_sel,
   input  logic              eng_window,
   output logic              disp_gnt,
   output logic              eng_gnt,
   output logic [ADDR_W:0]   mem_addr,
   output logic              mem_we
);

   logic w_eng_gnt;

   assign w_eng_gnt = eng_req & ~disp_req & eng_window;

   assign disp_gnt = disp_req;
   assign eng_gnt  = w_eng_gnt;
   assign mem_we   = w_eng_gnt & eng_we;

   always_comb begin
      mem_addr = '0;
      if (disp_req)
         mem_addr = {buf_sel, disp_addr};
      else if (w_eng_gnt)
         mem_addr = {~buf_sel, eng_addr};
   end

endmodule

// File: rtl/life_scheduler.sv
// Paces Game-of-Life generations against the video frame rate, hands the
// engine its start pulse, flips the displayed buffer on a frame boundary and
// arbitrates the shared cell memory between display and engine.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   IDLE        | paused; waiting for run or a latched single step
//   WAIT_FRAME  | counting frame_start pulses up to the speed target
//   COMPUTE     | engine running; waiting for gen_done
//   SWAP        | generation ready; flip buffers on next frame_start
//
// Ports:
//   clk_vga, rst             : pixel clock, synchronous active-high reset
//   frame_start, run, step   : frame pulse, free-run level, single-step pulse
//   speed                    : frames per generation select (1/4/15/60)
//   disp_*, eng_*            : memory requests from display and engine
//   disp_gnt, eng_gnt        : memory grants
//   mem_addr, mem_we         : cell memory address (MSB = buffer), write enable
//   gen_start, gen_done      : engine handshake pulses
//   buf_sel, gen_count, busy : displayed buffer, generations done, not idle
module life_scheduler
   import life_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int CNT_W  = 16
) (
   input  logic              clk_vga,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              run,
   input  logic              step,
   input  logic [1:0]        speed,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   input  logic              eng_req,
   input  logic              eng_we,
   input  logic [ADDR_W-1:0] eng_addr,
   output logic              disp_gnt,
   output logic              eng_gnt,
   output logic [ADDR_W:0]   mem_addr,
   output logic              mem_we,
   output logic              gen_start,
   input  logic              gen_done,
   output logic              buf_sel,
   output logic [CNT_W-1:0]  gen_count,
   output logic              busy
);

   life_state_t        r_state;
   logic               r_buf_sel;
   logic [CNT_W-1:0]   r_gen_count;
   logic [FRAME_W-1:0] r_frame_cnt;
   logic [FRAME_W-1:0] r_frame_target;
   logic               r_step_pend;
   logic               r_gen_start;

   logic [FRAME_W-1:0] w_frame_inc;
   logic               w_eng_window;

   assign w_frame_inc  = r_frame_cnt + 1'b1;
   assign w_eng_window = (r_state == ST_COMPUTE) & ~rst;

   always_ff @(posedge clk_vga) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_buf_sel      <= 1'b0;
         r_gen_count    <= '0;
         r_frame_cnt    <= '0;
         r_frame_target <= '0;
         r_step_pend    <= 1'b0;
         r_gen_start    <= 1'b0;
      end else begin
         r_gen_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!run && step)
                  r_step_pend <= 1'b1;
               if (run || r_step_pend) begin
                  r_state        <= ST_WAIT_FRAME;
                  r_frame_cnt    <= '0;
                  r_frame_target <= speed_frames(speed);
               end
            end

            ST_WAIT_FRAME: begin
               // Dropping run while only waiting (no step owed) just pauses;
               // no generation has been started yet.
               if (!run && !r_step_pend) begin
                  r_state <= ST_IDLE;
               end else if (frame_start) begin
                  if ((w_frame_inc == r_frame_target) || r_step_pend) begin
                     r_gen_start <= 1'b1;
                     r_step_pend <= 1'b0;
                     r_state     <= ST_COMPUTE;
                  end else begin
                     r_frame_cnt <= w_frame_inc;
                  end
               end
            end

            // frame_start is deliberately not looked at here, so a frame
            // coinciding with gen_done is not counted toward the swap.
            ST_COMPUTE: begin
               if (gen_done)
                  r_state <= ST_SWAP;
            end

            ST_SWAP: begin
               if (frame_start) begin
                  r_buf_sel   <= ~r_buf_sel;
                  r_gen_count <= r_gen_count + 1'b1;
                  if (run) begin
                     r_state        <= ST_WAIT_FRAME;
                     r_frame_cnt    <= '0;
                     r_frame_target <= speed_frames(speed);
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign gen_start = r_gen_start;
   assign buf_sel   = r_buf_sel;
   assign gen_count = r_gen_count;
   assign busy      = (r_state != ST_IDLE);

   life_mem_arbiter #(
      .ADDR_W (ADDR_W)
   ) u_arb (
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .eng_req    (eng_req),
      .eng_we     (eng_we),
      .eng_addr   (eng_addr),
      .buf_sel    (r_buf_sel),
      .eng_window (w_eng_window),
      .disp_gnt   (disp_gnt),
      .eng_gnt    (eng_gnt),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we)
   );

endmodule

// File: tb/tb_life_scheduler.sv
// Directed bench for life_scheduler. A second instance with an 8-bit
// generation counter exercises counter wrap in a short run.
module tb_life_scheduler;

   localparam int ADDR_W = 11;
   localparam int CNT_W  = 16;

   logic              clk_vga = 1'b0;
   logic              rst, frame_start, run, step, gen_done;
   logic [1:0]        speed;
   logic              disp_req, eng_req, eng_we;
   logic [ADDR_W-1:0] disp_addr, eng_addr;
   logic              disp_gnt, eng_gnt, mem_we, gen_start, buf_sel, busy;
   logic [ADDR_W:0]   mem_addr;
   logic [CNT_W-1:0]  gen_count;

   // wrap instance
   logic              rst_w, fs_w, run_w, gd_w;
   logic              tie0 = 1'b0;
   logic [1:0]        spd0 = 2'd0;
   logic [ADDR_W-1:0] addr0 = '0;
   logic              dg_w, eg_w, we_w, gs_w, bs_w, busy_w;
   logic [ADDR_W:0]   ma_w;
   logic [7:0]        cnt_w;

   int n_checks = 0;
   int n_pass   = 0;
   int n_gs     = 0;
   int gs0;

   always #20 clk_vga = ~clk_vga;

   always @(posedge clk_vga)
      if (gen_start === 1'b1) n_gs <= n_gs + 1;

   life_scheduler #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk_vga(clk_vga), .rst(rst), .frame_start(frame_start), .run(run),
      .step(step), .speed(speed), .disp_req(disp_req), .disp_addr(disp_addr),
      .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr),
      .disp_gnt(disp_gnt), .eng_gnt(eng_gnt), .mem_addr(mem_addr),
      .mem_we(mem_we), .gen_start(gen_start), .gen_done(gen_done),
      .buf_sel(buf_sel), .gen_count(gen_count), .busy(busy)
   );

   life_scheduler #(.ADDR_W(ADDR_W), .CNT_W(8)) u_wrap (
      .clk_vga(clk_vga), .rst(rst_w), .frame_start(fs_w), .run(run_w),
      .step(tie0), .speed(spd0), .disp_req(tie0), .disp_addr(addr0),
      .eng_req(tie0), .eng_we(tie0), .eng_addr(addr0),
      .disp_gnt(dg_w), .eng_gnt(eg_w), .mem_addr(ma_w),
      .mem_we(we_w), .gen_start(gs_w), .gen_done(gd_w),
      .buf_sel(bs_w), .gen_count(cnt_w), .busy(busy_w)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk_vga);
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic pulse_gd();
      gen_done = 1'b1;
      tick();
      gen_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1; frame_start = 1'b0; run = 1'b0; step = 1'b0; gen_done = 1'b0;
      speed = 2'd0; disp_req = 1'b0; eng_req = 1'b0; eng_we = 1'b0;
      disp_addr = '0; eng_addr = '0;
      rst_w = 1'b1; fs_w = 1'b0; run_w = 1'b0; gd_w = 1'b0;

      // reset state
      repeat (2) tick();
      chk("rst_busy", busy, 0);
      chk("rst_buf", buf_sel, 0);
      chk("rst_cnt", gen_count, 0);
      chk("rst_gs", gen_start, 0);
      rst = 1'b0;

      // free run at one frame per generation
      run = 1'b1; speed = 2'd0;
      tick();
      chk("run_busy", busy, 1);
      repeat (3) tick();
      pulse_fs();
      chk("g1_gs_hi", gen_start, 1);
      tick();
      chk("g1_gs_lo", gen_start, 0);
      repeat (98) tick();
      pulse_gd();
      chk("g1_swap_buf", buf_sel, 0);
      chk("g1_swap_busy", busy, 1);
      repeat (3) tick();
      pulse_fs();
      chk("g1_buf", buf_sel, 1);
      chk("g1_cnt", gen_count, 1);

      // second generation; run drops mid-compute, frame and done coincide
      tick();
      pulse_fs();
      chk("g2_gs_hi", gen_start, 1);
      run = 1'b0;
      tick();
      pulse_fs();
      repeat (96) tick();
      frame_start = 1'b1; gen_done = 1'b1;
      tick();
      frame_start = 1'b0; gen_done = 1'b0;
      chk("fsgd_buf", buf_sel, 1);
      chk("fsgd_cnt", gen_count, 1);
      chk("fsgd_busy", busy, 1);
      pulse_fs();
      chk("g2_buf", buf_sel, 0);
      chk("g2_cnt", gen_count, 2);
      chk("g2_idle", busy, 0);

      // single step while paused; step during compute ignored
      gs0 = n_gs;
      step = 1'b1; tick(); step = 1'b0;
      tick();
      chk("step_busy", busy, 1);
      tick();
      pulse_fs();
      chk("step_gs", gen_start, 1);
      step = 1'b1; tick(); step = 1'b0;
      repeat (3) tick();
      pulse_gd();
      pulse_fs();
      chk("step_cnt", gen_count, 3);
      chk("step_idle", busy, 0);
      repeat (3) tick();
      pulse_fs();
      repeat (3) tick();
      chk("step_idle2", busy, 0);
      chk("step_one_gs", n_gs - gs0, 1);

      // speed 1 (4 frames), changed to 3 mid-wait
      speed = 2'd1; run = 1'b1;
      tick(); tick();
      gs0 = n_gs;
      for (int f = 1; f <= 4; f++) begin
         if (f == 3) speed = 2'd3;
         pulse_fs();
         tick();
         chk($sformatf("spd1_f%0d", f), n_gs - gs0, (f == 4) ? 1 : 0);
      end
      pulse_gd();
      pulse_fs();
      chk("g4_cnt", gen_count, 4);
      tick();
      gs0 = n_gs;
      for (int f = 1; f <= 60; f++) begin
         pulse_fs();
         tick();
         if (f == 59 || f == 60)
            chk($sformatf("spd3_f%0d", f), n_gs - gs0, (f == 60) ? 1 : 0);
      end

      // arbitration during compute, displayed buffer 0
      eng_req = 1'b1; eng_we = 1'b1; eng_addr = 11'd5; disp_addr = 11'd7;
      for (int i = 0; i < 6; i++) begin
         disp_req = (i % 2 == 1);
         #1;
         chk($sformatf("arb%0d_eng", i), eng_gnt, !disp_req);
         chk($sformatf("arb%0d_addr", i), mem_addr,
             disp_req ? 32'd7 : ((32'd1 << ADDR_W) | 32'd5));
         chk($sformatf("arb%0d_we", i), mem_we, !disp_req);
         chk($sformatf("arb%0d_both", i), disp_gnt & eng_gnt, 0);
         tick();
      end
      disp_req = 1'b0;
      speed = 2'd0;
      pulse_gd();
      #1;
      chk("swap_eng_gnt", eng_gnt, 0);
      tick();
      pulse_fs();
      chk("g5_buf", buf_sel, 1);
      chk("g5_cnt", gen_count, 5);
      pulse_fs();
      #1;
      chk("buf1_eng_gnt", eng_gnt, 1);
      chk("buf1_addr", mem_addr, 5);

      // reset while computing
      rst = 1'b1;
      #1;
      chk("rstc_eng_gnt", eng_gnt, 0);
      chk("rstc_we", mem_we, 0);
      disp_req = 1'b1;
      #1;
      chk("rstc_disp", disp_gnt, 1);
      disp_req = 1'b0;
      tick();
      chk("rstc_busy", busy, 0);
      chk("rstc_buf", buf_sel, 0);
      chk("rstc_cnt", gen_count, 0);
      run = 1'b0; rst = 1'b0;
      pulse_gd();
      tick();
      chk("late_gd_busy", busy, 0);
      chk("late_gd_cnt", gen_count, 0);
      chk("idle_eng_gnt", eng_gnt, 0);
      eng_req = 1'b0; eng_we = 1'b0;

      // counter wrap on the 8-bit instance
      rst_w = 1'b0; run_w = 1'b1; fs_w = 1'b1; gd_w = 1'b1;
      for (int k = 0; k < 2000 && cnt_w != 8'hFF; k++) tick();
      fs_w = 1'b0; gd_w = 1'b0;
      chk("wrap_reach_ff", cnt_w, 8'hFF);
      fs_w = 1'b1; tick(); fs_w = 1'b0;
      gd_w = 1'b1; tick(); gd_w = 1'b0;
      fs_w = 1'b1; tick(); fs_w = 1'b0;
      chk("wrap_cnt", cnt_w, 8'h00);
      chk("wrap_buf", bs_w, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
